// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its PLL / downstream-reset environment.
// The supervisor uses the slave view; whoever drives lock status and software requests uses master.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       locked_stable;
    logic [7:0] lock_loss_count;
    logic [7:0] timeout_count;

    modport master (
        output pll_locked,
        output sw_reset_req,
        input  pll_rst,
        input  sys_reset_n,
        input  locked_stable,
        input  lock_loss_count,
        input  timeout_count
    );

    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        output pll_rst,
        output sys_reset_n,
        output locked_stable,
        output lock_loss_count,
        output timeout_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock acquisition and stabilization, and holds the PLL-domain
// logic in reset until the synchronized lock has been steady long enough.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.slave  bus
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_sync;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pll_rst_q;
    logic             sys_reset_n_q;
    logic             locked_stable_q;
    logic [7:0]       lock_loss_q;
    logic [7:0]       timeout_q;

    // pll_locked is asynchronous; nothing but the last flop of this chain is ever looked at.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q         <= PLL_RESET;
            cnt_q           <= '0;
            pll_rst_q       <= 1'b1;
            sys_reset_n_q   <= 1'b0;
            locked_stable_q <= 1'b0;
            lock_loss_q     <= 8'd0;
            timeout_q       <= 8'd0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (bus.sw_reset_req) begin
                        state_q   <= PLL_RESET;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else if (locked_sync) begin
                        state_q <= STABILIZE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= PLL_RESET;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        timeout_q <= (timeout_q == 8'hFF) ? timeout_q : timeout_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                // Any low sample of locked_sync throws away all stabilization progress.
                STABILIZE: begin
                    if (bus.sw_reset_req) begin
                        state_q   <= PLL_RESET;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else if (!locked_sync) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q         <= RUN;
                        cnt_q           <= '0;
                        sys_reset_n_q   <= 1'b1;
                        locked_stable_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    cnt_q <= '0;
                    if (!locked_sync) begin
                        lock_loss_q <= (lock_loss_q == 8'hFF) ? lock_loss_q : lock_loss_q + 8'd1;
                    end
                    if (bus.sw_reset_req) begin
                        state_q         <= PLL_RESET;
                        pll_rst_q       <= 1'b1;
                        sys_reset_n_q   <= 1'b0;
                        locked_stable_q <= 1'b0;
                    end else if (!locked_sync) begin
                        state_q         <= WAIT_LOCK;
                        sys_reset_n_q   <= 1'b0;
                        locked_stable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q         <= PLL_RESET;
                    cnt_q           <= '0;
                    pll_rst_q       <= 1'b1;
                    sys_reset_n_q   <= 1'b0;
                    locked_stable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst         = pll_rst_q;
    assign bus.sys_reset_n     = sys_reset_n_q;
    assign bus.locked_stable   = locked_stable_q;
    assign bus.lock_loss_count = lock_loss_q;
    assign bus.timeout_count   = timeout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed timing scenarios plus a random
// lock/unlock stream compared against a phase-and-elapsed-time reference model.
module tb_pll_lock_supervisor;

    localparam int SYNC_STAGES    = 2;
    localparam int PLL_RST_CYCLES = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT   = 32;

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAB  = 2;
    localparam int M_RUN   = 3;

    logic refclk;
    logic rst_n;

    pll_lock_supervisor_if bus();

    pll_lock_supervisor #(
        .SYNC_STAGES    (SYNC_STAGES),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: which phase we are in, the edge it began on, and a delay line for lock.
    int   m_phase;
    int   m_cyc   = 0;
    int   m_since = 0;
    int   m_ll    = 0;
    int   m_to    = 0;
    logic m_hist[$];

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic m_enter(input int p);
        m_phase = p;
        m_since = m_cyc;
    endtask

    task automatic model_edge(input logic lk, input logic sw, input logic rn);
        logic ls;
        int   el;
        m_cyc++;
        if (rn !== 1'b1) begin
            m_enter(M_PULSE);
            m_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
            m_ll = 0;
            m_to = 0;
            return;
        end
        ls = m_hist[SYNC_STAGES-1];
        m_hist.push_front(lk);
        void'(m_hist.pop_back());
        el = m_cyc - m_since;
        case (m_phase)
            M_PULSE: if (el == PLL_RST_CYCLES) m_enter(M_WAIT);
            M_WAIT: begin
                if (sw === 1'b1) m_enter(M_PULSE);
                else if (ls === 1'b1) m_enter(M_STAB);
                else if (el == LOCK_TIMEOUT) begin
                    m_enter(M_PULSE);
                    m_to = sat255(m_to + 1);
                end
            end
            M_STAB: begin
                if (sw === 1'b1) m_enter(M_PULSE);
                else if (ls !== 1'b1) m_enter(M_WAIT);
                else if (el == STABLE_CYCLES) m_enter(M_RUN);
            end
            default: begin
                if (ls !== 1'b1) m_ll = sat255(m_ll + 1);
                if (sw === 1'b1) m_enter(M_PULSE);
                else if (ls !== 1'b1) m_enter(M_WAIT);
            end
        endcase
    endtask

    task automatic step();
        model_edge(bus.pll_locked, bus.sw_reset_req, rst_n);
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_rst_level(input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.pll_rst === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_sys_level(input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.sys_reset_n === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.sw_reset_req = 1'b0;
        repeat (3) step();
        tests_run++;
        if (bus.pll_rst !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_pll_rst: got %b expected 1", bus.pll_rst);
        end
        tests_run++;
        if (bus.sys_reset_n !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sys_reset_n: got %b expected 0", bus.sys_reset_n);
        end
        tests_run++;
        if (bus.locked_stable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_locked_stable: got %b expected 0", bus.locked_stable);
        end
        tests_run++;
        if (bus.lock_loss_count !== 8'd0 || bus.timeout_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", bus.lock_loss_count, bus.timeout_count);
        end
    endtask

    task automatic test_pulse_width();
        int  n;
        logic bad;
        bad = 1'b0;
        rst_n = 1'b1;
        wait_rst_level(1'b0, n);
        tests_run++;
        if (n != PLL_RST_CYCLES) begin
            tests_failed++;
            $display("[TB] FAIL pulse_width: got %0d edges expected %0d", n, PLL_RST_CYCLES);
        end
        repeat (5) begin
            step();
            if (bus.sys_reset_n !== 1'b0 || bus.pll_rst !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("[TB] FAIL wait_lock_outputs: got pll_rst=%b sys_reset_n=%b expected 0/0", bus.pll_rst, bus.sys_reset_n);
        end
    endtask

    task automatic test_lock_acquire();
        int n;
        bus.pll_locked = 1'b1;
        wait_sys_level(1'b1, n);
        tests_run++;
        if (n != SYNC_STAGES + STABLE_CYCLES + 1) begin
            tests_failed++;
            $display("[TB] FAIL lock_acquire_latency: got %0d edges expected %0d", n, SYNC_STAGES + STABLE_CYCLES + 1);
        end
        tests_run++;
        if (bus.locked_stable !== 1'b1 || bus.pll_rst !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL run_outputs: got locked_stable=%b pll_rst=%b expected 1/0", bus.locked_stable, bus.pll_rst);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        bus.pll_locked = 1'b0;
        wait_sys_level(1'b0, n);
        tests_run++;
        if (n != 3) begin
            tests_failed++;
            $display("[TB] FAIL lock_loss_latency: got %0d edges expected 3", n);
        end
        tests_run++;
        if (bus.lock_loss_count !== 8'd1 || bus.locked_stable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lock_loss_count: got %0d stable=%b expected 1 stable=0", bus.lock_loss_count, bus.locked_stable);
        end
        bus.pll_locked = 1'b1;
        wait_sys_level(1'b1, n);
        tests_run++;
        if (n != 11) begin
            tests_failed++;
            $display("[TB] FAIL relock_latency: got %0d edges expected 11", n);
        end
    endtask

    task automatic test_stabilize_glitch();
        int n;
        bus.pll_locked = 1'b0;
        wait_sys_level(1'b0, n);
        bus.pll_locked = 1'b1;
        repeat (8) step();
        bus.pll_locked = 1'b0;
        repeat (2) step();
        bus.pll_locked = 1'b1;
        wait_sys_level(1'b1, n);
        tests_run++;
        if (n != 11) begin
            tests_failed++;
            $display("[TB] FAIL glitch_restart: got %0d edges expected 11", n);
        end
        tests_run++;
        if (bus.lock_loss_count !== 8'd2) begin
            tests_failed++;
            $display("[TB] FAIL glitch_loss_count: got %0d expected 2", bus.lock_loss_count);
        end
    endtask

    task automatic test_sw_in_pulse();
        int n;
        bus.sw_reset_req = 1'b1;
        step();
        bus.sw_reset_req = 1'b0;
        tests_run++;
        if (bus.pll_rst !== 1'b1 || bus.sys_reset_n !== 1'b0 || bus.lock_loss_count !== 8'd2) begin
            tests_failed++;
            $display("[TB] FAIL sw_reset_from_run: got pll_rst=%b sys=%b loss=%0d expected 1/0/2", bus.pll_rst, bus.sys_reset_n, bus.lock_loss_count);
        end
        bus.sw_reset_req = 1'b1;
        step();
        bus.sw_reset_req = 1'b0;
        wait_rst_level(1'b0, n);
        tests_run++;
        if (n + 1 != PLL_RST_CYCLES) begin
            tests_failed++;
            $display("[TB] FAIL sw_ignored_in_pulse: got width %0d expected %0d", n + 1, PLL_RST_CYCLES);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        wait_sys_level(1'b1, n);
        tests_run++;
        if (n < 0) begin
            tests_failed++;
            $display("[TB] FAIL reach_run_before_reset: got timeout expected sys_reset_n=1");
        end
        rst_n = 1'b0;
        step();
        tests_run++;
        if (bus.pll_rst !== 1'b1 || bus.sys_reset_n !== 1'b0 || bus.lock_loss_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got pll_rst=%b sys=%b loss=%0d expected 1/0/0", bus.pll_rst, bus.sys_reset_n, bus.lock_loss_count);
        end
        rst_n = 1'b1;
        wait_rst_level(1'b0, n);
        tests_run++;
        if (n != PLL_RST_CYCLES) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_pulse: got %0d edges expected %0d", n, PLL_RST_CYCLES);
        end
    endtask

    task automatic test_sw_with_lock_loss();
        int n;
        wait_sys_level(1'b1, n);
        bus.pll_locked = 1'b0;
        repeat (2) step();
        bus.sw_reset_req = 1'b1;
        step();
        bus.sw_reset_req = 1'b0;
        tests_run++;
        if (bus.pll_rst !== 1'b1 || bus.sys_reset_n !== 1'b0 || bus.locked_stable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sw_loss_outputs: got pll_rst=%b sys=%b stable=%b expected 1/0/0", bus.pll_rst, bus.sys_reset_n, bus.locked_stable);
        end
        tests_run++;
        if (bus.lock_loss_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL sw_loss_count: got %0d expected 1", bus.lock_loss_count);
        end
        wait_rst_level(1'b0, n);
        tests_run++;
        if (n != PLL_RST_CYCLES) begin
            tests_failed++;
            $display("[TB] FAIL sw_loss_pulse: got %0d edges expected %0d", n, PLL_RST_CYCLES);
        end
    endtask

    task automatic test_timeout();
        int n0;
        int n1;
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_rst_level(1'b0, n0);
            wait_rst_level(1'b1, n1);
            tests_run++;
            if (n0 + n1 != PLL_RST_CYCLES + LOCK_TIMEOUT) begin
                tests_failed++;
                $display("[TB] FAIL timeout_period_%0d: got %0d edges expected %0d", k, n0 + n1, PLL_RST_CYCLES + LOCK_TIMEOUT);
            end
            tests_run++;
            if (bus.timeout_count !== 8'(k)) begin
                tests_failed++;
                $display("[TB] FAIL timeout_count_%0d: got %0d expected %0d", k, bus.timeout_count, k);
            end
        end
        for (int k = 4; k <= 300; k++) begin
            wait_rst_level(1'b0, n0);
            wait_rst_level(1'b1, n1);
            tests_run++;
            if (n0 < 0 || n1 < 0) begin
                tests_failed++;
                $display("[TB] FAIL timeout_progress_%0d: got no pll_rst pulse expected one", k);
                break;
            end
        end
        tests_run++;
        if (bus.timeout_count !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL timeout_saturate: got %0d expected 255", bus.timeout_count);
        end
    endtask

    task automatic test_random();
        int         hold;
        int         fails_here;
        logic [19:0] got;
        logic [19:0] exp;
        hold = 0;
        fails_here = 0;
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.sw_reset_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4000 && fails_here < 10; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.pll_locked = 1'b1;
                    hold = int'($urandom_range(1, 30));
                end else begin
                    bus.pll_locked = 1'b0;
                    hold = int'($urandom_range(1, 6));
                end
            end
            hold--;
            bus.sw_reset_req = ($urandom_range(0, 149) == 0);
            rst_n = ($urandom_range(0, 699) != 0);
            step();
            got = {1'b0, bus.pll_rst, bus.sys_reset_n, bus.locked_stable, bus.lock_loss_count, bus.timeout_count};
            exp = {1'b0, m_phase == M_PULSE, m_phase == M_RUN, m_phase == M_RUN, 8'(m_ll), 8'(m_to)};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                fails_here++;
                $display("[TB] FAIL random_cycle_%0d: got %h expected %h", c, got, exp);
            end
        end
        bus.sw_reset_req = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.sw_reset_req = 1'b0;
        test_reset();
        test_pulse_width();
        test_lock_acquire();
        test_lock_loss();
        test_stabilize_glitch();
        test_sw_in_pulse();
        test_mid_reset();
        test_sw_with_lock_loss();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
